viterbi_acs_unit: RTL and testbench
===================================

// Module: viterbi_acs_unit
// PURPOSE
//  Branch-metric and add-compare-select (ACS) stage of the hard-decision Viterbi decoder.
//  It consumes one received 2-bit code symbol per handshake and updates all 2^(K-1) path metrics in parallel.
//  It emits one survivor-decision vector per symbol, with the current best state, to the traceback stage (depth D_TB), which sits directly downstream.
// PARAMETERS
//  K       5     constraint length; NS = 2^(K-1) states (16)
//  G0_OCT  023   generator 0, octal; the MSB taps the current input bit
//  G1_OCT  035   generator 1, octal
//  PM_W    6     path-metric width, modulo arithmetic
//  PM_INIT 16    start metric loaded into every state except state 0
// PORTS
//  clk          in   1      clock; all logic is rising-edge
//  rst          in   1      synchronous, active-high reset; top level drives rst = ~rst_n
//  in_valid     in   1      rx_sym is valid
//  in_ready     out  1      ACS can accept a symbol
//  in_start     in   1      first symbol of a frame; qualified by in_valid
//  rx_sym       in   2      received bits: [1] = g0 output, [0] = g1 output
//  out_valid    out  1      surv/best_state are valid
//  out_ready    in   1      traceback accepts the output
//  out_start    out  1      in_start of the symbol that produced this output
//  surv         out  NS     decision bit per next state
//  best_state   out  K-1    index of the minimum-metric state after this update
// BEHAVIOUR
//  - Trellis:
//    - s' = {u, s[K-2:1]}.
//    - Encoder register r = {u, s}; g0 = ^(r & G0_OCT), g1 = ^(r & G1_OCT).
//    - Predecessors of s' = {u, p} are {p,0} (surv = 0) and {p,1} (surv = 1).
//  - Branch metric: Hamming distance between rx_sym and {g0, g1}; range 0..2.
//  - ACS: cand = pm[pred] + bm, computed mod 2^PM_W.
//    - Compare with "a < b" := (a - b)[PM_W-1] (modulo compare). No renormalisation logic.
//    - Max spread <= PM_INIT + 2(K-1) = 24 < 2^(PM_W-1).
//    - Tie: pick predecessor {p,0}, so surv = 0.
//  - Frame start: when in_start is set on an accepted symbol, the ACS uses the initial metrics (pm[0] = 0, others = PM_INIT) as the old metrics.
//  - Handshake:
//    - Accept = in_valid & in_ready, with in_ready = !out_valid | out_ready.
//    - On accept, new pm, surv, best_state and out_start are registered and out_valid is set. Latency is 1 cycle.
//    - out_valid is cleared on out_ready when no new accept occurs in the same cycle.
//    - Simultaneous out_ready and accept: new output replaces old in the same cycle, out_valid stays 1; full throughput, 1 symbol per clock.
//    - While out_valid & !out_ready: outputs and pm are held stable; in_ready = 0.
//  - best_state: minimum over the new metrics by modulo compare; ties resolve to the lowest index.
//  - Reset:
//    - out_valid = 0, out_start = 0, surv = 0, best_state = 0.
//    - pm[0] = 0, others = PM_INIT.
//    - Reset mid-frame discards the held output; no partial state survives.
//  - in_start without in_valid is ignored; rx_sym is don't-care when in_valid = 0.
// STRUCTURE
//  viterbi_pkg:
//    - constants K, NS, G0_OCT, G1_OCT, PM_W, PM_INIT
//    - function exp_sym(state, u) returning {g0, g1}
//    - function pm_lt(a, b) implementing the modulo compare
//  Sub-module viterbi_acs_butterfly:
//    - inputs: pm{p,0}, pm{p,1} and their 4 branch metrics
//    - outputs: new pm and surv for s' = {0,p} and {1,p}
//    - instantiated NS/2 times
//  Parent holds the metric register, the handshake and the best-state compare tree.
// TESTING
//  1. Reset, then idle -> out_valid = 0, in_ready = 1, pm[0] = 0, pm[1..15] = 16.
//  2. in_start + rx = 11 from reset -> state 8 metric 0, best_state = 8, surv[8] = 0; 1 cycle after accept.
//  3. 40 symbols of rx = 00 with in_start on the first -> best_state = 0 every output, pm[0] stays 0, surv[0] = 0.
//  4. Encode 0x5A3C (bit-serial) via reference model, flip one rx bit at symbol 7:
//     - best_state tracks the encoder state except at/after the flip as the model predicts;
//     - the best metric ends at 1.
//  5. Hold out_ready = 0 for 5 cycles with in_valid = 1:
//     - in_ready = 0, outputs stable;
//     - on release, one transfer per cycle, no symbol lost or duplicated.
//  6. 10,000 random rx symbols vs. a full-width behavioural model:
//     - surv and best_state match every symbol, covering metric wrap;
//     - also assert rst mid-stream and check the initial metrics are restored.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Purpose: shared constants, types and trellis helpers for the Viterbi ACS stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package viterbi_pkg;

    localparam int K       = 5;
    localparam int NS      = 1 << (K - 1);
    localparam int PM_W    = 6;
    localparam int PM_INIT = 16;

    // Generators in octal; bit K-1 taps the current input bit u.
    localparam logic [K-1:0] G0_OCT = 5'o23;
    localparam logic [K-1:0] G1_OCT = 5'o35;

    typedef logic [PM_W-1:0] pm_t;
    typedef logic [K-2:0]    state_t;

    // Expected code symbol {g0, g1} when leaving 'state' with input bit 'u'.
    function automatic logic [1:0] exp_sym(input state_t state, input logic u);
        logic [K-1:0] r;
        r = {u, state};
        return {^(r & G0_OCT), ^(r & G1_OCT)};
    endfunction

    // Modulo "a < b": valid because metric spread stays below 2^(PM_W-1).
    function automatic logic pm_lt(input pm_t a, input pm_t b);
        pm_t d;
        d = a - b;
        return d[PM_W-1];
    endfunction

endpackage

// File: rtl/viterbi_acs_unit_if.sv
// Purpose: symbol-in / decision-out handshake bundle of the ACS stage.
// Latency: n/a (signal bundle).
// Backpressure: in_ready driven by the ACS; out_ready driven by the traceback side.
// Ports: master = symbol source + traceback sink view, slave = ACS view.
interface viterbi_acs_unit_if;
    import viterbi_pkg::*;

    logic           in_valid;
    logic           in_ready;
    logic           in_start;
    logic [1:0]     rx_sym;
    logic           out_valid;
    logic           out_ready;
    logic           out_start;
    logic [NS-1:0]  surv;
    state_t         best_state;

    modport master (
        output in_valid, in_start, rx_sym, out_ready,
        input  in_ready, out_valid, out_start, surv, best_state
    );

    modport slave (
        input  in_valid, in_start, rx_sym, out_ready,
        output in_ready, out_valid, out_start, surv, best_state
    );

endinterface

// File: rtl/viterbi_acs_butterfly.sv
// Purpose: one radix-2 ACS butterfly: predecessors {p,0},{p,1} -> next states {0,p},{1,p}.
// Latency: combinational.
// Backpressure: none (pure datapath, parent owns the handshake).
// Ports: i_pm0/i_pm1 old metrics of {p,0}/{p,1}; i_bm*_u* branch metrics per
//        predecessor and input bit; o_pm_u*/o_surv_u* new metric and decision
//        for next state {u,p}.
module viterbi_acs_butterfly
    import viterbi_pkg::*;
(
    input  pm_t        i_pm0,
    input  pm_t        i_pm1,
    input  logic [1:0] i_bm0_u0,
    input  logic [1:0] i_bm1_u0,
    input  logic [1:0] i_bm0_u1,
    input  logic [1:0] i_bm1_u1,
    output pm_t        o_pm_u0,
    output logic       o_surv_u0,
    output pm_t        o_pm_u1,
    output logic       o_surv_u1
);

    pm_t w_c0_u0, w_c1_u0, w_c0_u1, w_c1_u1;

    assign w_c0_u0 = i_pm0 + {{(PM_W-2){1'b0}}, i_bm0_u0};
    assign w_c1_u0 = i_pm1 + {{(PM_W-2){1'b0}}, i_bm1_u0};
    assign w_c0_u1 = i_pm0 + {{(PM_W-2){1'b0}}, i_bm0_u1};
    assign w_c1_u1 = i_pm1 + {{(PM_W-2){1'b0}}, i_bm1_u1};

    // Odd predecessor wins only when strictly better, so ties give surv = 0.
    assign o_surv_u0 = pm_lt(w_c1_u0, w_c0_u0);
    assign o_surv_u1 = pm_lt(w_c1_u1, w_c0_u1);
    assign o_pm_u0   = o_surv_u0 ? w_c1_u0 : w_c0_u0;
    assign o_pm_u1   = o_surv_u1 ? w_c1_u1 : w_c0_u1;

endmodule

// File: rtl/viterbi_acs_unit.sv
// Purpose: branch metric + add-compare-select over all NS states, one symbol per accept.
// Latency: 1 cycle from accept to out_valid; full throughput (1 symbol/clock).
// Backpressure: in_ready = !out_valid | out_ready; metrics and outputs hold while stalled.
// Ports: clk, rst (sync active-high); bus = slave side of viterbi_acs_unit_if
//        carrying the symbol input handshake and the survivor/best-state output.
module viterbi_acs_unit
    import viterbi_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    viterbi_acs_unit_if.slave    bus
);

    pm_t           r_pm [NS];
    logic          r_out_valid;
    logic          r_out_start;
    logic [NS-1:0] r_surv;
    state_t        r_best;

    pm_t           w_pm_init [NS];
    pm_t           w_pm_old  [NS];
    pm_t           w_pm_new  [NS];
    logic [1:0]    w_bm      [NS][2];
    logic [NS-1:0] w_surv;
    state_t        w_best;
    logic          w_in_ready;
    logic          w_accept;

    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;

    // A frame start restarts from the initial metrics instead of the stored ones.
    always_comb begin
        for (int s = 0; s < NS; s++) begin
            w_pm_init[s] = (s == 0) ? '0 : pm_t'(PM_INIT);
            w_pm_old[s]  = bus.in_start ? w_pm_init[s] : r_pm[s];
        end
    end

    // Hamming distance between the received symbol and each branch label.
    always_comb begin
        logic [1:0] d;
        for (int s = 0; s < NS; s++) begin
            for (int u = 0; u < 2; u++) begin
                d           = bus.rx_sym ^ exp_sym(state_t'(s), u[0]);
                w_bm[s][u]  = {1'b0, d[1]} + {1'b0, d[0]};
            end
        end
    end

    for (genvar p = 0; p < NS/2; p++) begin : g_bfly
        viterbi_acs_butterfly u_bfly (
            .i_pm0     (w_pm_old[2*p]),
            .i_pm1     (w_pm_old[2*p+1]),
            .i_bm0_u0  (w_bm[2*p][0]),
            .i_bm1_u0  (w_bm[2*p+1][0]),
            .i_bm0_u1  (w_bm[2*p][1]),
            .i_bm1_u1  (w_bm[2*p+1][1]),
            .o_pm_u0   (w_pm_new[p]),
            .o_surv_u0 (w_surv[p]),
            .o_pm_u1   (w_pm_new[p+NS/2]),
            .o_surv_u1 (w_surv[p+NS/2])
        );
    end

    // Pairwise minimum tree. The left operand always carries the lower
    // indices, so keeping it on a tie yields the lowest-index minimum.
    always_comb begin
        state_t t_idx [K][NS];
        pm_t    t_val [K][NS];
        for (int l = 0; l < K; l++) begin
            for (int i = 0; i < NS; i++) begin
                t_idx[l][i] = '0;
                t_val[l][i] = '0;
            end
        end
        for (int i = 0; i < NS; i++) begin
            t_idx[0][i] = state_t'(i);
            t_val[0][i] = w_pm_new[i];
        end
        for (int l = 0; l < K-1; l++) begin
            for (int i = 0; i < NS/2; i++) begin
                if (i < (NS >> (l+1))) begin
                    if (pm_lt(t_val[l][2*i+1], t_val[l][2*i])) begin
                        t_idx[l+1][i] = t_idx[l][2*i+1];
                        t_val[l+1][i] = t_val[l][2*i+1];
                    end else begin
                        t_idx[l+1][i] = t_idx[l][2*i];
                        t_val[l+1][i] = t_val[l][2*i];
                    end
                end
            end
        end
        w_best = t_idx[K-1][0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NS; s++) begin
                r_pm[s] <= (s == 0) ? '0 : pm_t'(PM_INIT);
            end
            r_out_valid <= 1'b0;
            r_out_start <= 1'b0;
            r_surv      <= '0;
            r_best      <= '0;
        end else if (w_accept) begin
            for (int s = 0; s < NS; s++) begin
                r_pm[s] <= w_pm_new[s];
            end
            r_out_valid <= 1'b1;
            r_out_start <= bus.in_start;
            r_surv      <= w_surv;
            r_best      <= w_best;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_start  = r_out_start;
    assign bus.surv       = r_surv;
    assign bus.best_state = r_best;

endmodule

// File: tb/tb_viterbi_acs_unit.sv
// Purpose: directed self-checking bench for viterbi_acs_unit against a
//          full-width (non-wrapping) forward-trellis model.
// Latency/backpressure: exercised by the stall/release and throughput steps.
module tb_viterbi_acs_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    viterbi_acs_unit_if u_if ();

    viterbi_acs_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    // Reference model state: full-width metrics, never wrap.
    int          mpm [16];
    logic [15:0] exp_surv;
    int          exp_best;
    int          exp_min;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mpm[i] = (i == 0) ? 0 : 16;
    endtask

    // Forward pass: every (state, u) edge relaxes its successor. States are
    // visited in ascending order, so the even predecessor is seen first and
    // a strict "<" keeps it on ties.
    task automatic model_step(input logic start, input logic [1:0] sym);
        int          nm [16];
        logic [15:0] sv;
        int          ns, bm, c;
        logic        g0, g1;
        logic [3:0]  sb;
        if (start) model_reset();
        for (int i = 0; i < 16; i++) nm[i] = 32'h3fff_ffff;
        sv = '0;
        for (int s = 0; s < 16; s++) begin
            sb = 4'(s);
            for (int u = 0; u < 2; u++) begin
                ns = (u << 3) | (s >> 1);
                g0 = u[0] ^ sb[1] ^ sb[0];
                g1 = u[0] ^ sb[3] ^ sb[2] ^ sb[0];
                bm = int'(sym[1] ^ g0) + int'(sym[0] ^ g1);
                c  = mpm[s] + bm;
                if (c < nm[ns]) begin
                    nm[ns] = c;
                    sv[ns] = sb[0];
                end
            end
        end
        exp_best = 0;
        for (int i = 0; i < 16; i++) begin
            mpm[i] = nm[i];
            if (nm[i] < nm[exp_best]) exp_best = i;
        end
        exp_min  = nm[exp_best];
        exp_surv = sv;
    endtask

    // One accepted symbol with the sink always ready, then check the result.
    task automatic send(input string tag, input logic start, input logic [1:0] sym);
        u_if.in_valid  = 1'b1;
        u_if.in_start  = start;
        u_if.rx_sym    = sym;
        u_if.out_ready = 1'b1;
        tick();
        u_if.in_valid  = 1'b0;
        u_if.in_start  = 1'b0;
        model_step(start, sym);
        chk({tag, "_vld"},   32'(u_if.out_valid),  32'd1);
        chk({tag, "_start"}, 32'(u_if.out_start),  32'(start));
        chk({tag, "_surv"},  32'(u_if.surv),       32'(exp_surv));
        chk({tag, "_best"},  32'(u_if.best_state), 32'(exp_best));
    endtask

    initial begin
        logic [15:0] data;
        logic [3:0]  es;
        logic        u;
        logic [1:0]  sym;
        logic [1:0]  stall_syms [4];
        int          k;

        u_if.in_valid  = 1'b0;
        u_if.in_start  = 1'b0;
        u_if.rx_sym    = 2'b00;
        u_if.out_ready = 1'b0;
        model_reset();

        // 1. Reset then idle.
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_out_valid", 32'(u_if.out_valid), 32'd0);
        chk("rst_in_ready",  32'(u_if.in_ready),  32'd1);
        chk("rst_out_start", 32'(u_if.out_start), 32'd0);
        chk("rst_surv",      32'(u_if.surv),      32'd0);
        chk("rst_best",      32'(u_if.best_state), 32'd0);
        for (int i = 0; i < 16; i++)
            chk("rst_pm", 32'(dut.r_pm[i]), (i == 0) ? 32'd0 : 32'd16);

        // 2. First symbol 11 from reset: state 8 reaches metric 0.
        u_if.in_valid = 1'b1; u_if.in_start = 1'b1; u_if.rx_sym = 2'b11;
        #1;
        chk("t2_pre_valid", 32'(u_if.out_valid), 32'd0);
        u_if.in_valid = 1'b0;
        send("t2", 1'b1, 2'b11);
        chk("t2_best_const", 32'(u_if.best_state), 32'd8);
        chk("t2_surv8",      32'(u_if.surv[8]),    32'd0);
        chk("t2_pm8",        32'(dut.r_pm[8]),     32'd0);

        // 3. All-zero stream stays in state 0 with metric 0.
        for (int i = 0; i < 40; i++) begin
            send("t3", i == 0, 2'b00);
            chk("t3_best0", 32'(u_if.best_state), 32'd0);
            chk("t3_surv0", 32'(u_if.surv[0]),    32'd0);
        end
        chk("t3_pm0", 32'(dut.r_pm[0]), 32'd0);

        // 4. Encoded 0x5A3C, MSB first, with one bit flipped at symbol 7.
        data = 16'h5A3C;
        es   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            u   = data[15-i];
            sym = {u ^ es[1] ^ es[0], u ^ es[3] ^ es[2] ^ es[0]};
            es  = {u, es[3:1]};
            if (i == 7) sym = sym ^ 2'b01;
            send("t4", i == 0, sym);
            if (i < 7) chk("t4_track", 32'(u_if.best_state), 32'(es));
        end
        chk("t4_best_metric", 32'(dut.r_pm[u_if.best_state]), 32'd1);

        // 5. Stall with in_valid held, then release at full rate.
        u_if.out_ready = 1'b1;
        tick();
        chk("t5_drained", 32'(u_if.out_valid), 32'd0);
        stall_syms[0] = 2'b01; stall_syms[1] = 2'b10;
        stall_syms[2] = 2'b11; stall_syms[3] = 2'b00;
        u_if.out_ready = 1'b0;
        u_if.in_valid  = 1'b1;
        u_if.in_start  = 1'b1;
        u_if.rx_sym    = stall_syms[0];
        tick();
        model_step(1'b1, stall_syms[0]);
        u_if.in_start = 1'b0;
        u_if.rx_sym   = stall_syms[1];
        for (int c = 0; c < 5; c++) begin
            chk("t5_in_ready", 32'(u_if.in_ready),   32'd0);
            chk("t5_hold_vld", 32'(u_if.out_valid),  32'd1);
            chk("t5_hold_srv", 32'(u_if.surv),       32'(exp_surv));
            chk("t5_hold_bst", 32'(u_if.best_state), 32'(exp_best));
            tick();
        end
        u_if.out_ready = 1'b1;
        #1;
        chk("t5_release_rdy", 32'(u_if.in_ready), 32'd1);
        for (int n = 1; n < 4; n++) begin
            u_if.rx_sym = stall_syms[n];
            tick();
            model_step(1'b0, stall_syms[n]);
            chk("t5_flow_vld", 32'(u_if.out_valid),  32'd1);
            chk("t5_flow_srv", 32'(u_if.surv),       32'(exp_surv));
            chk("t5_flow_bst", 32'(u_if.best_state), 32'(exp_best));
        end
        u_if.in_valid = 1'b0;
        tick();
        chk("t5_no_dup", 32'(u_if.out_valid), 32'd0);

        // 6. Random stream with metric wrap and a reset mid-stream.
        k = 0;
        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) begin
                u_if.in_valid = 1'b1; u_if.rx_sym = 2'b10; u_if.out_ready = 1'b0;
                tick();
                model_step(1'b0, 2'b10);
                u_if.in_valid = 1'b0;
                rst = 1'b1;
                tick();
                rst = 1'b0;
                model_reset();
                chk("t6_rst_vld",   32'(u_if.out_valid),  32'd0);
                chk("t6_rst_best",  32'(u_if.best_state), 32'd0);
                chk("t6_rst_surv",  32'(u_if.surv),       32'd0);
                chk("t6_rst_pm0",   32'(dut.r_pm[0]),     32'd0);
                chk("t6_rst_pm5",   32'(dut.r_pm[5]),     32'd16);
                chk("t6_rst_pm15",  32'(dut.r_pm[15]),    32'd16);
            end
            sym = 2'($urandom_range(0, 3));
            send("t6", i == 0, sym);
            k++;
        end
        for (int i = 0; i < 16; i++)
            chk("t6_pm_wrap", 32'(dut.r_pm[i]), 32'(mpm[i] & 63));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
